// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard used by decode for hazard stalls.
module regfile_mp_scoreboard #(
  parameter int               XLEN     = 32,
  parameter int               NREGS    = 32,
  parameter int               NRD      = 2,
  parameter int               NWR      = 2,
  parameter bit               BYPASS   = 1'b1,
  parameter logic [XLEN-1:0]  SP_RESET = XLEN'(32'h0000_7FFC),
  parameter logic [XLEN-1:0]  GP_RESET = XLEN'(32'hFFFF_FC00),
  localparam int              AW       = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR-1:0][AW-1:0]    wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data,
  input  logic                      issue_en,
  input  logic [AW-1:0]             issue_addr,
  output logic [NREGS-1:0]          busy_vec
);

  logic [XLEN-1:0]  regs    [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val  [NREGS];
  logic [NREGS-1:0] busy_next;

  function automatic logic [XLEN-1:0] reset_value(input int idx);
    case (idx)
      2:       return SP_RESET;
      3:       return GP_RESET;
      default: return '0;
    endcase
  endfunction

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-index port wins a same-address conflict.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_val[i] = '0;
    end
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p] != '0)) begin
        wr_hit[wr_addr[p]] = 1'b1;
        wr_val[wr_addr[p]] = wr_data[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        regs[i] <= reset_value(i);
      end else if (wr_hit[i]) begin
        regs[i] <= wr_val[i];
      end
    end
  end

  // A new issue supersedes a completing writeback to the same register.
  always_comb begin
    busy_next = busy_vec;
    for (int i = 1; i < NREGS; i++) begin
      if (issue_en && (issue_addr == AW'(i))) begin
        busy_next[i] = 1'b1;
      end else if (wr_hit[i]) begin
        busy_next[i] = 1'b0;
      end
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  // Bypass is deliberately not gated by reset: forwarded data is still valid
  // on the wires even though the edge will not store it.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_data[r] = '0;
      rd_busy[r] = 1'b0;
      if (rd_addr[r] != '0) begin
        if (BYPASS && wr_hit[rd_addr[r]]) begin
          rd_data[r] = wr_val[rd_addr[r]];
          rd_busy[r] = 1'b0;
        end else begin
          rd_data[r] = regs[rd_addr[r]];
          rd_busy[r] = busy_vec[rd_addr[r]];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp_scoreboard.md
# regfile_mp_scoreboard

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard. It serves the pipelined core that follows the single-cycle CPU. Decode reads operands and marks destinations busy at issue. Writeback ports clear busy as results return. Hazard detection uses `rd_busy` to stall decode.

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of architectural registers (power of 2, ≥4); `AW = $clog2(NREGS)`
- `NRD`, 2, number of read ports (1–4)
- `NWR`, 2, number of write ports (1–2)
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored values
- `SP_RESET`, 32'h0000_7FFC, reset value of x2 (stack pointer)
- `GP_RESET`, 32'hFFFF_FC00, reset value of x3 (MMIO base)

Ports:
- `clk` in 1 — clock, all state updates on rising edge
- `reset` in 1 — synchronous, active-high
- `rd_addr` in NRD×AW — read port addresses
- `rd_data` out NRD×XLEN — read data (combinational)
- `rd_busy` out NRD — addressed register has an outstanding producer (combinational)
- `wr_en` in NWR — write port enables
- `wr_addr` in NWR×AW — write addresses
- `wr_data` in NWR×XLEN — write data
- `issue_en` in 1 — mark `issue_addr` busy
- `issue_addr` in AW — destination register being issued
- `busy_vec` out NREGS — registered scoreboard, bit i = register i busy

## Operation
- Reset takes one edge with `reset`=1:
  - regs[2] ← SP_RESET, regs[3] ← GP_RESET, all other registers ← 0.
  - `busy_vec` ← 0.
  - Writes and issues in the same cycle are ignored.
- Register 0:
  - Always reads 0 and `rd_busy`=0.
  - Writes and issues to address 0 are discarded; `busy_vec[0]` is constant 0.
- Writes: for each port p with `wr_en[p]` and `wr_addr[p]`≠0, regs[wr_addr[p]] ← wr_data[p] at the edge.
- Write conflict: if both ports write the same non-zero address in one cycle, the higher port index (port 1) wins, for storage and for bypass.
- Scoreboard update per register i≠0, evaluated at the edge:
  - Set if `issue_en` && `issue_addr`==i.
  - Else clear if any enabled write port targets i.
  - Else hold.
  - Issue has priority over write-clear on the same register in the same cycle, because the new producer supersedes the completing one.
- Read data per port r:
  - If `rd_addr[r]`==0 → 0.
  - Else if BYPASS=1 and some enabled write port targets `rd_addr[r]` this cycle → that port's `wr_data` (highest index wins).
  - Else stored value.
- Read busy per port r:
  - Equals `busy_vec[rd_addr[r]]`.
  - Exception: with BYPASS=1, a same-cycle enabled write to that address forces `rd_busy[r]`=0, since the data is available now.
  - A same-cycle issue does not affect `rd_busy` until the next cycle.
- WAW: issuing to an already-busy register is legal; busy stays set. Any write then clears it. Tracking of the latest producer is the pipeline's responsibility.
- All arithmetic is index comparison only. No wrap-around: NREGS is a power of 2, so every address is valid.

## Timing
- Read path is purely combinational: zero-cycle latency from `rd_addr`/`wr_*` to `rd_data`/`rd_busy`.
- Write latency, BYPASS=0: stored value is visible on reads the cycle after `wr_en`.
- Write latency, BYPASS=1: value is visible the same cycle and persists.
- `busy_vec` is registered: it changes one edge after `issue_en` or write.
- Reset mid-operation overrides all pending writes and issues in that cycle. `rd_data` reflects reset values the cycle after the reset edge. Bypass stays active during reset cycles, but nothing is stored.
- Contents before the first reset are undefined; the bench must reset first.

## Test plan
- Reset, then read x2, x3, x5 → 32'h0000_7FFC, 32'hFFFF_FC00, 0; `busy_vec`=0.
- Write x7←32'hDEAD_BEEF with BYPASS=1, reading x7 the same cycle → `rd_data`=32'hDEAD_BEEF that cycle. With BYPASS=0 → old value that cycle, 32'hDEAD_BEEF the next cycle.
- Both write ports target x9 with 32'h1111 (port 0) and 32'h2222 (port 1) → x9 = 32'h2222; bypass also returns 32'h2222.
- Issue x4, then read x4 → `rd_busy`=1 next cycle. Write x4 = 5 two cycles later → `rd_busy`=0 in the write cycle (BYPASS=1), `busy_vec[4]`=0 after the edge.
- Issue x6 and write x6 in the same cycle → `busy_vec[6]`=1 after the edge; x6 stores the written value.
- Write x0←32'hFFFF_FFFF and issue x0 → x0 reads 0, `busy_vec[0]`=0. Assert reset together with a write to x2 → x2 = SP_RESET.
